ov7670_capture: RTL and testbench

Downstream neighbour of the OV7670 configuration controller. Once camera configuration has finished, this block takes the camera's parallel pixel bus (VSYNC, HREF, 8-bit data), pairs bytes into 16-bit RGB565 pixels and emits linear frame-buffer write strobes. It also reports frame boundaries and framing errors. It feeds the frame-buffer RAM write port.

---
 rtl/ov7670_pkg.sv | 17 +
 rtl/ov7670_capture_if.sv | 29 ++
 rtl/ov7670_sync_edge.sv | 44 ++++
 rtl/ov7670_capture.sv | 163 ++++++++++++++++
 tb/tb_ov7670_capture.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared capture-path types and constants for the OV7670 camera blocks
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE
    } state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W = 16;

    // SCCB write address of the sensor, shared with the configuration controller
    localparam logic [7:0] CAMERA_ADDR = 8'h42;

endpackage

// File: rtl/ov7670_capture_if.sv
// ov7670_capture_if: camera parallel bus in, frame-buffer write port and status out
interface ov7670_capture_if #(
    parameter int ADDR_W = 19
);
    import ov7670_pkg::*;

    logic              enable;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              line_error;
    logic              overflow;

    modport master (
        output enable, cam_vsync, cam_href, cam_data,
        input  wr_en, wr_addr, wr_data, frame_done, frame_count, line_error, overflow
    );

    modport slave (
        input  enable, cam_vsync, cam_href, cam_data,
        output wr_en, wr_addr, wr_data, frame_done, frame_count, line_error, overflow
    );

endinterface

// File: rtl/ov7670_sync_edge.sv
// ov7670_sync_edge: one register stage on the camera bus plus VSYNC/HREF edge detection
module ov7670_sync_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    output logic       href_o,
    output logic [7:0] data_o,
    output logic       vs_rise_o,
    output logic       vs_fall_o,
    output logic       hr_fall_o
);

    logic       vs_q;
    logic       vs_p_q;
    logic       hr_q;
    logic       hr_p_q;
    logic [7:0] d_q;

    // Register the bus once and keep the previous sync levels for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q   <= 1'b0;
            vs_p_q <= 1'b0;
            hr_q   <= 1'b0;
            hr_p_q <= 1'b0;
            d_q    <= '0;
        end else begin
            vs_q   <= vsync_i;
            vs_p_q <= vs_q;
            hr_q   <= href_i;
            hr_p_q <= hr_q;
            d_q    <= data_i;
        end
    end

    assign href_o    = hr_q;
    assign data_o    = d_q;
    assign vs_rise_o = vs_q & ~vs_p_q;
    assign vs_fall_o = ~vs_q & vs_p_q;
    assign hr_fall_o = ~hr_q & hr_p_q;

endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: pairs camera bytes into RGB565 pixels and issues linear frame-buffer writes
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 19
) (
    input logic               clk,
    input logic               reset,
    ov7670_capture_if.slave   bus
);

    // One extra bit so the saturation point fits even when it equals 2^ADDR_W
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

    logic             hr;
    logic [7:0]       d;
    logic             vs_rise;
    logic             vs_fall;
    logic             hr_fall;

    state_t           state_q,       state_d;
    logic             phase_q,       phase_d;
    logic [7:0]       hi_q,          hi_d;
    logic [ADDR_W:0]  addr_q,        addr_d;
    logic [15:0]      x_q,           x_d;
    logic [15:0]      y_q,           y_d;
    logic             wr_en_q,       wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [PIX_W-1:0] wr_data_q,     wr_data_d;
    logic             frame_done_q,  frame_done_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             line_error_q,  line_error_d;
    logic             overflow_q,    overflow_d;

    ov7670_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .vsync_i   (bus.cam_vsync),
        .href_i    (bus.cam_href),
        .data_i    (bus.cam_data),
        .href_o    (hr),
        .data_o    (d),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hr_fall_o (hr_fall)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state plus byte pairing, addressing and frame bookkeeping
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        addr_d        = addr_q;
        x_d           = x_q;
        y_d           = y_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        line_error_d  = line_error_q;
        overflow_d    = overflow_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_FRAME;
                WAIT_FRAME: begin
                    if (vs_fall) begin
                        state_d      = ACTIVE;
                        addr_d       = '0;
                        x_d          = '0;
                        y_d          = '0;
                        phase_d      = 1'b0;
                        line_error_d = 1'b0;
                        overflow_d   = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (hr) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            hi_d = d;
                        end else begin
                            x_d = x_q + 16'd1;
                            if (addr_q < TOTAL) begin
                                wr_en_d   = 1'b1;
                                wr_data_d = {hi_q, d};
                                wr_addr_d = addr_q[ADDR_W-1:0];
                                addr_d    = addr_q + (ADDR_W+1)'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end else begin
                        phase_d = 1'b0;
                        if (hr_fall) begin
                            line_error_d = line_error_q | phase_q;
                            x_d          = '0;
                            if (x_q != '0) y_d = y_q + 16'd1;
                        end
                    end
                    // Frame end wins over a half pixel; a completed pixel still writes
                    if (vs_rise) begin
                        state_d       = WAIT_FRAME;
                        phase_d       = 1'b0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= 1'b0;
            hi_q          <= '0;
            addr_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            line_error_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            addr_q        <= addr_d;
            x_q           <= x_d;
            y_q           <= y_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            line_error_q  <= line_error_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.line_error  = line_error_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: scoreboard bench for the OV7670 pixel capture block
module tb_ov7670_capture;
    import ov7670_pkg::*;

    localparam int H = 4;
    localparam int V = 4;
    localparam int AW = 4;
    localparam int TOTAL = H * V;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        int            c;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ov7670_capture_if #(.ADDR_W(AW)) bus ();

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   fd_cnt = 0;
    int   exp_addr = 0;
    int   exp_fc = 0;
    int   last_wr_cyc = -1;
    int   last_fd_cyc = -1;
    logic fd_prev = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write monitor: pops the scoreboard on every strobe, also checks frame_done width
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.wr_en) begin
                    wr_cnt++;
                    last_wr_cyc = cyc;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got addr=%0d data=%h cyc=%0d, expected no write", bus.wr_addr, bus.wr_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.wr_addr !== e.a || bus.wr_data !== e.d || cyc != e.c) begin
                            n_fail++;
                            $display("FAIL write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d", bus.wr_addr, bus.wr_data, cyc, e.a, e.d, e.c);
                        end
                    end
                end
                if (bus.frame_done) begin
                    fd_cnt++;
                    last_fd_cyc = cyc;
                    n_tests++;
                    if (fd_prev) begin
                        n_fail++;
                        $display("FAIL frame_done_width: got high on two consecutive cycles at cyc=%0d, expected one", cyc);
                    end
                end
            end
            fd_prev = bus.frame_done;
        end
    end

    task automatic send_line(input int nbytes, input int base, input bit vs_last, input bit expect_wr);
        logic [7:0] b0;
        b0 = '0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 8'(base + i);
            if (vs_last && i == nbytes - 1) bus.cam_vsync = 1'b1;
            if (i % 2 == 0) begin
                b0 = 8'(base + i);
            end else if (expect_wr && exp_addr < TOTAL) begin
                exp_q.push_back('{a: AW'(exp_addr), d: {b0, 8'(base + i)}, c: cyc + 2});
                exp_addr++;
            end
        end
        @(negedge clk);
        bus.cam_href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        bus.cam_vsync = 1'b0;
        exp_addr = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end(input bit counts);
        @(negedge clk);
        bus.cam_vsync = 1'b1;
        if (counts) exp_fc = (exp_fc + 1) % 256;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.cam_vsync = 1'b1;
        bus.cam_href = 1'b0;
        bus.cam_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_count, bus.line_error, bus.overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h fd=%b fc=%0d lerr=%b ovf=%b, expected all 0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_count, bus.line_error, bus.overflow);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame();
        int wc0 = wr_cnt;
        int fd0 = fd_cnt;
        frame_start();
        for (int l = 0; l < 4; l++) send_line(8, l * 8, 1'b0, 1'b1);
        frame_end(1'b1);
        n_tests++;
        if (wr_cnt - wc0 != 16) begin n_fail++; $display("FAIL frame_writes: got %0d, expected 16", wr_cnt - wc0); end
        n_tests++;
        if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d, expected 1", fd_cnt - fd0); end
        n_tests++;
        if (bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL frame_count: got %0d, expected %0d", bus.frame_count, exp_fc); end
        n_tests++;
        if (bus.line_error !== 1'b0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL frame_flags: got lerr=%b ovf=%b, expected 0 0", bus.line_error, bus.overflow); end
        n_tests++;
        if (bus.wr_addr !== 4'd15 || bus.wr_data !== 16'h1E1F) begin n_fail++; $display("FAIL frame_hold: got addr=%0d data=%h, expected 15 1e1f", bus.wr_addr, bus.wr_data); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_missing: got %0d writes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_odd_line();
        int wc0 = wr_cnt;
        frame_start();
        send_line(8, 0, 1'b0, 1'b1);
        n_tests++;
        if (bus.line_error !== 1'b0) begin n_fail++; $display("FAIL odd_before: got line_error=%b, expected 0", bus.line_error); end
        send_line(7, 8, 1'b0, 1'b1);
        n_tests++;
        if (bus.line_error !== 1'b1) begin n_fail++; $display("FAIL odd_after: got line_error=%b, expected 1", bus.line_error); end
        send_line(8, 16, 1'b0, 1'b1);
        send_line(8, 24, 1'b0, 1'b1);
        frame_end(1'b1);
        n_tests++;
        if (wr_cnt - wc0 != 15) begin n_fail++; $display("FAIL odd_writes: got %0d, expected 15", wr_cnt - wc0); end
        n_tests++;
        if (bus.line_error !== 1'b1 || bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL odd_end: got lerr=%b fc=%0d, expected 1 %0d", bus.line_error, bus.frame_count, exp_fc); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL odd_missing: got %0d writes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_overflow();
        int wc0 = wr_cnt;
        int fd0 = fd_cnt;
        frame_start();
        n_tests++;
        if (bus.line_error !== 1'b0) begin n_fail++; $display("FAIL lerr_clear: got line_error=%b, expected 0", bus.line_error); end
        for (int l = 0; l < 5; l++) send_line(8, l * 8, 1'b0, 1'b1);
        frame_end(1'b1);
        n_tests++;
        if (wr_cnt - wc0 != 16) begin n_fail++; $display("FAIL ovf_writes: got %0d, expected 16", wr_cnt - wc0); end
        n_tests++;
        if (bus.wr_addr !== 4'd15 || bus.wr_data !== 16'h1E1F) begin n_fail++; $display("FAIL ovf_hold: got addr=%0d data=%h, expected 15 1e1f", bus.wr_addr, bus.wr_data); end
        n_tests++;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got overflow=%b, expected 1", bus.overflow); end
        n_tests++;
        if (fd_cnt - fd0 != 1 || bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL ovf_frame: got fd=%0d fc=%0d, expected 1 %0d", fd_cnt - fd0, bus.frame_count, exp_fc); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_missing: got %0d writes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_enable_drop();
        int wc0;
        int fd0;
        logic [7:0] b0;
        b0 = '0;
        frame_start();
        n_tests++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got overflow=%b, expected 0", bus.overflow); end
        wc0 = wr_cnt;
        fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 8'(64 + i);
            if (i == 11) bus.enable = 1'b0;
            if (i % 2 == 0) begin
                b0 = 8'(64 + i);
            end else if (i < 10) begin
                exp_q.push_back('{a: AW'(exp_addr), d: {b0, 8'(64 + i)}, c: cyc + 2});
                exp_addr++;
            end
        end
        @(negedge clk);
        bus.cam_href = 1'b0;
        repeat (3) @(negedge clk);
        frame_end(1'b0);
        n_tests++;
        if (wr_cnt - wc0 != 5) begin n_fail++; $display("FAIL drop_writes: got %0d, expected 5", wr_cnt - wc0); end
        n_tests++;
        if (fd_cnt != fd0 || bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL drop_frame: got fd=%0d fc=%0d, expected 0 %0d", fd_cnt - fd0, bus.frame_count, exp_fc); end
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        wc0 = wr_cnt;
        frame_start();
        for (int l = 0; l < 4; l++) send_line(8, 128 + l * 8, 1'b0, 1'b1);
        frame_end(1'b1);
        n_tests++;
        if (wr_cnt - wc0 != 16 || bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL reenable: got writes=%0d fc=%0d, expected 16 %0d", wr_cnt - wc0, bus.frame_count, exp_fc); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL reenable_missing: got %0d writes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_simultaneous();
        int wc0 = wr_cnt;
        int fd0 = fd_cnt;
        frame_start();
        send_line(8, 0, 1'b0, 1'b1);
        send_line(8, 8, 1'b1, 1'b1);
        exp_fc = (exp_fc + 1) % 256;
        repeat (3) @(negedge clk);
        n_tests++;
        if (fd_cnt - fd0 != 1 || last_fd_cyc != last_wr_cyc) begin n_fail++; $display("FAIL sim_pixel: got fd=%0d fd_cyc=%0d wr_cyc=%0d, expected 1 and equal cycles", fd_cnt - fd0, last_fd_cyc, last_wr_cyc); end
        n_tests++;
        if (wr_cnt - wc0 != 8) begin n_fail++; $display("FAIL sim_writes: got %0d, expected 8", wr_cnt - wc0); end
        wc0 = wr_cnt;
        frame_start();
        send_line(8, 32, 1'b0, 1'b1);
        send_line(7, 40, 1'b1, 1'b1);
        exp_fc = (exp_fc + 1) % 256;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.line_error !== 1'b0 || bus.frame_count !== 8'(exp_fc)) begin n_fail++; $display("FAIL sim_half: got lerr=%b fc=%0d, expected 0 %0d", bus.line_error, bus.frame_count, exp_fc); end
        n_tests++;
        if (wr_cnt - wc0 != 7 || exp_q.size() != 0) begin n_fail++; $display("FAIL sim_half_writes: got %0d outstanding %0d, expected 7 0", wr_cnt - wc0, exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_midline();
        int wc0;
        int fd0;
        logic [7:0] b0;
        b0 = '0;
        frame_start();
        wc0 = wr_cnt;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 8'(16 + i);
            if (i % 2 == 0) begin
                b0 = 8'(16 + i);
            end else begin
                exp_q.push_back('{a: AW'(exp_addr), d: {b0, 8'(16 + i)}, c: cyc + 2});
                exp_addr++;
            end
        end
        @(posedge clk);
        #2;
        n_tests++;
        if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wr_en: got %b, expected 1", bus.wr_en); end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_count, bus.line_error, bus.overflow} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got wr_en=%b addr=%0d data=%h fd=%b fc=%0d lerr=%b ovf=%b, expected all 0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_count, bus.line_error, bus.overflow);
        end
        exp_q.delete();
        exp_fc = 0;
        @(negedge clk);
        reset = 1'b0;
        fd0 = fd_cnt;
        send_line(8, 80, 1'b0, 1'b0);
        send_line(8, 88, 1'b0, 1'b0);
        frame_end(1'b0);
        n_tests++;
        if (wr_cnt - wc0 != 2) begin n_fail++; $display("FAIL post_reset_writes: got %0d, expected 2", wr_cnt - wc0); end
        n_tests++;
        if (fd_cnt != fd0 || bus.frame_count !== 8'd0) begin n_fail++; $display("FAIL post_reset_frame: got fd=%0d fc=%0d, expected 0 0", fd_cnt - fd0, bus.frame_count); end
    endtask

    task automatic test_back_to_back();
        int fd0 = fd_cnt;
        for (int f = 0; f < 256; f++) begin
            frame_start();
            send_line(2, f, 1'b0, 1'b1);
            frame_end(1'b1);
            if (f == 254) begin
                n_tests++;
                if (bus.frame_count !== 8'd255) begin n_fail++; $display("FAIL count_255: got %0d, expected 255", bus.frame_count); end
            end
        end
        n_tests++;
        if (bus.frame_count !== 8'(exp_fc) || exp_fc != 0) begin n_fail++; $display("FAIL count_wrap: got %0d, expected 0", bus.frame_count); end
        n_tests++;
        if (fd_cnt - fd0 != 256) begin n_fail++; $display("FAIL b2b_frame_done: got %0d, expected 256", fd_cnt - fd0); end
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d writes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_odd_line();
        test_overflow();
        test_enable_drop();
        test_simultaneous();
        test_reset_midline();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
